// File: rtl/traffic_demand_arbiter_pkg.sv
// Shared types and constants for the traffic demand arbiter.
// Holds direction codes, arbiter states and the round-robin picker.
package traffic_demand_arbiter_pkg;

    localparam int unsigned NUM_DIR          = 4;
    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_E = 2'd0,
        DIR_W = 2'd1,
        DIR_N = 2'd2,
        DIR_S = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_EMG      = 2'd2,
        ST_EMG_HOLD = 2'd3
    } arb_state_e;

    // First set bit searching upward from last+1; the downward scan lets
    // the nearest candidate overwrite the farther ones.
    function automatic logic [1:0] rr_pick(
        input logic [NUM_DIR-1:0] req,
        input logic [1:0]         last
    );
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last + 2'd1;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/traffic_demand_arbiter_det_debounce.sv
// One loop-detector lane: 2-FF synchroniser and saturating debounce counter.
// Emits a single-cycle qualified pulse when the count reaches its limit.
module traffic_demand_arbiter_det_debounce
    import traffic_demand_arbiter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic det_i,
    input  logic clr_i,
    output logic qualified_o
);

    localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CYC);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       qual_q;
    logic       qual_d;

    always_comb begin
        cnt_d  = cnt_q;
        qual_d = 1'b0;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (!sync_q[1]) begin
            cnt_d = 4'd0;
        end else if (cnt_q != LIMIT) begin
            cnt_d  = cnt_q + 4'd1;
            qual_d = (cnt_q == LIMIT - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
            cnt_q  <= 4'd0;
            qual_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], det_i};
            cnt_q  <= cnt_d;
            qual_q <= qual_d;
        end
    end

    assign qualified_o = qual_q;

endmodule

// File: rtl/traffic_demand_arbiter.sv
// Turns four loop detectors plus an emergency request into a valid/ready
// stream of phase requests: sticky demands, round-robin, emergency first.
module traffic_demand_arbiter
    import traffic_demand_arbiter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       det_e,
    input  logic       det_w,
    input  logic       det_n,
    input  logic       det_s,
    input  logic       emg,
    input  logic [1:0] emg_dir,
    output logic       req_valid,
    output logic [1:0] req_dir,
    output logic       req_emg,
    input  logic       req_ready,
    output logic [3:0] pending
);

    logic [NUM_DIR-1:0] det_raw;
    logic [NUM_DIR-1:0] qual;
    logic [NUM_DIR-1:0] clr_vec;
    logic [NUM_DIR-1:0] pending_q;
    logic [NUM_DIR-1:0] pending_d;

    logic       emg_meta_q;
    logic       emg_sync_q;
    logic       emg_q;
    logic [1:0] edir_meta_q;
    logic [1:0] edir_sync_q;
    logic [1:0] edir_q;

    arb_state_e state_q;
    arb_state_e state_d;
    logic [1:0] dir_q;
    logic [1:0] dir_d;
    logic [1:0] last_q;
    logic [1:0] last_d;

    assign det_raw = {det_s, det_n, det_w, det_e};

    for (genvar i = 0; i < NUM_DIR; i++) begin : g_det
        traffic_demand_arbiter_det_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .det_i      (det_raw[i]),
            .clr_i      (clr_vec[i]),
            .qualified_o(qual[i])
        );
    end

    // Extra stage after the synchroniser lines the emergency path up with
    // the detector qualification pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            emg_meta_q  <= 1'b0;
            emg_sync_q  <= 1'b0;
            emg_q       <= 1'b0;
            edir_meta_q <= 2'd0;
            edir_sync_q <= 2'd0;
            edir_q      <= 2'd0;
        end else begin
            emg_meta_q  <= emg;
            emg_sync_q  <= emg_meta_q;
            emg_q       <= emg_sync_q;
            edir_meta_q <= emg_dir;
            edir_sync_q <= edir_meta_q;
            edir_q      <= edir_sync_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        last_d    = last_q;
        clr_vec   = '0;
        req_valid = 1'b0;
        req_emg   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (emg_q) begin
                    dir_d   = edir_q;
                    state_d = ST_EMG;
                end else if (|pending_q) begin
                    dir_d   = rr_pick(pending_q, last_q);
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    clr_vec[dir_q] = 1'b1;
                    last_d         = dir_q;
                    state_d        = ST_IDLE;
                end
            end
            ST_EMG: begin
                req_valid = 1'b1;
                req_emg   = 1'b1;
                if (req_ready) begin
                    clr_vec[dir_q] = 1'b1;
                    state_d        = ST_EMG_HOLD;
                end
            end
            ST_EMG_HOLD: begin
                if (!emg_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear beats a coincident qualify so a granted lane must re-qualify.
    assign pending_d = (pending_q | qual) & ~clr_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_E;
            last_q    <= DIR_S;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_q    <= last_d;
            pending_q <= pending_d;
        end
    end

    assign req_dir = dir_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_traffic_demand_arbiter.sv
// Cycle-vector bench for traffic_demand_arbiter with DEBOUNCE_CYC=4.
// Vectors feed a scoreboard queue; corner cases are hand sequences.
module tb_traffic_demand_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       det_e = 1'b0;
    logic       det_w = 1'b0;
    logic       det_n = 1'b0;
    logic       det_s = 1'b0;
    logic       emg = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic       req_valid;
    logic [1:0] req_dir;
    logic       req_emg;
    logic       req_ready = 1'b0;
    logic [3:0] pending;

    always #5 clk = ~clk;

    traffic_demand_arbiter #(
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .det_e    (det_e),
        .det_w    (det_w),
        .det_n    (det_n),
        .det_s    (det_s),
        .emg      (emg),
        .emg_dir  (emg_dir),
        .req_valid(req_valid),
        .req_dir  (req_dir),
        .req_emg  (req_emg),
        .req_ready(req_ready),
        .pending  (pending)
    );

    typedef struct {
        logic       rst;
        logic [3:0] det;
        logic       emg;
        logic [1:0] edir;
        logic       rdy;
        logic       v;
        logic [1:0] d;
        logic       e;
        logic [3:0] p;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sbq[$];
    int         checks = 0;
    int         errors = 0;

    task automatic add(
        input int         n,
        input logic       r,
        input logic [3:0] det,
        input logic       em,
        input logic [1:0] ed,
        input logic       rd,
        input logic       v,
        input logic [1:0] d,
        input logic       e,
        input logic [3:0] p
    );
        vec_t x;
        x.rst = r;  x.det = det; x.emg = em; x.edir = ed; x.rdy = rd;
        x.v = v;    x.d = d;     x.e = e;    x.p = p;
        repeat (n) vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got v=%0b d=%0d e=%0b p=%b want v=%0b d=%0d e=%0b p=%b",
                     name, got[7], got[6:5], got[4], got[3:0],
                     want[7], want[6:5], want[4], want[3:0]);
        end
    endtask

    function automatic logic [7:0] outs();
        return {req_valid, req_dir, req_emg, pending};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // single east demand, grant and clear
        add(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(6, 1, 4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b0001, 0, 0, 1, 0, 0, 0, 4'b0001);
        add(1, 1, 4'b0000, 0, 0, 1, 1, 0, 0, 4'b0001);
        add(2, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        // 3-cycle north glitch rejected, 4-cycle west pulse accepted
        add(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(3, 1, 4'b0100, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(7, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(4, 1, 4'b0010, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(2, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0010);
        add(1, 1, 4'b0000, 0, 0, 1, 1, 1, 0, 4'b0010);
        add(2, 1, 4'b0000, 0, 0, 1, 0, 1, 0, 4'b0000);
        // all four held: E W N S E with re-qualification
        add(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(6, 1, 4'b1111, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b1111, 0, 0, 1, 0, 0, 0, 4'b1111);
        add(1, 1, 4'b1111, 0, 0, 1, 1, 0, 0, 4'b1111);
        add(1, 1, 4'b1111, 0, 0, 1, 0, 0, 0, 4'b1110);
        add(1, 1, 4'b1111, 0, 0, 1, 1, 1, 0, 4'b1110);
        add(1, 1, 4'b1111, 0, 0, 1, 0, 1, 0, 4'b1100);
        add(1, 1, 4'b1111, 0, 0, 1, 1, 2, 0, 4'b1100);
        add(1, 1, 4'b1111, 0, 0, 1, 0, 2, 0, 4'b1000);
        add(1, 1, 4'b1111, 0, 0, 1, 1, 3, 0, 4'b1001);
        add(1, 1, 4'b1111, 0, 0, 1, 0, 3, 0, 4'b0001);
        add(1, 1, 4'b1111, 0, 0, 1, 1, 0, 0, 4'b0011);
        add(1, 1, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0010);
        // backpressure with other detectors toggling
        add(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(5, 1, 4'b0001, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b0101, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b0101, 0, 0, 1, 0, 0, 0, 4'b0001);
        add(1, 1, 4'b0111, 0, 0, 0, 1, 0, 0, 4'b0001);
        add(1, 1, 4'b0101, 0, 0, 0, 1, 0, 0, 4'b0001);
        add(1, 1, 4'b0111, 0, 0, 0, 1, 0, 0, 4'b0001);
        add(1, 1, 4'b0101, 0, 0, 0, 1, 0, 0, 4'b0001);
        add(1, 1, 4'b0111, 0, 0, 0, 1, 0, 0, 4'b0101);
        add(1, 1, 4'b0100, 0, 0, 0, 1, 0, 0, 4'b0101);
        add(1, 1, 4'b0110, 0, 0, 1, 0, 0, 0, 4'b0100);
        add(1, 1, 4'b0000, 0, 0, 1, 1, 2, 0, 4'b0100);
        add(2, 1, 4'b0000, 0, 0, 1, 0, 2, 0, 4'b0000);
        // emergency north over pending E/W, single offer per assertion
        add(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 4'b0000);
        add(4, 1, 4'b0011, 0, 2, 1, 0, 0, 0, 4'b0000);
        add(2, 1, 4'b0011, 1, 2, 1, 0, 0, 0, 4'b0000);
        add(1, 1, 4'b0011, 1, 2, 1, 0, 0, 0, 4'b0011);
        add(1, 1, 4'b0011, 1, 2, 1, 1, 2, 1, 4'b0011);
        add(2, 1, 4'b0011, 1, 2, 1, 0, 2, 0, 4'b0011);
        add(4, 1, 4'b0011, 0, 2, 1, 0, 2, 0, 4'b0011);
        add(1, 1, 4'b0000, 0, 2, 1, 1, 0, 0, 4'b0011);
        add(1, 1, 4'b0000, 0, 2, 1, 0, 0, 0, 4'b0010);
        add(1, 1, 4'b0000, 0, 2, 1, 1, 1, 0, 4'b0010);
        add(1, 1, 4'b0000, 0, 2, 1, 0, 1, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            {det_s, det_n, det_w, det_e} = vecs[i].det;
            emg = vecs[i].emg;
            emg_dir = vecs[i].edir;
            req_ready = vecs[i].rdy;
            sbq.push_back({vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].p});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), sbq.pop_front());
        end

        // emergency arriving during an offer waits for the transfer
        @(negedge clk);
        rst = 1'b0;
        {det_s, det_n, det_w, det_e} = 4'b0000;
        emg = 1'b0;
        req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        det_e = 1'b1;
        n = 0;
        while (!req_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("offer_e", {4'b0, req_valid, req_dir, req_emg},
              {4'b0, 1'b1, 2'd0, 1'b0});
        @(negedge clk);
        det_e = 1'b0;
        emg = 1'b1;
        emg_dir = 2'd1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("no_preempt%0d", k),
                  {4'b0, req_valid, req_dir, req_emg},
                  {4'b0, 1'b1, 2'd0, 1'b0});
        end
        @(negedge clk);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        check("xfer_e", {4'b0, req_valid, req_dir, req_emg},
              {4'b0, 1'b0, 2'd0, 1'b0});
        @(negedge clk);
        req_ready = 1'b0;
        det_s = 1'b1;
        @(posedge clk);
        #1;
        check("emg_next", {4'b0, req_valid, req_dir, req_emg},
              {4'b0, 1'b1, 2'd1, 1'b1});

        // asynchronous reset while an emergency offer and demand are live
        n = 0;
        while (!pending[3] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pre_rst", outs(), {1'b1, 2'd1, 1'b1, 4'b1000});
        #2;
        rst = 1'b0;
        #1;
        check("async_rst", outs(), 8'h00);
        @(negedge clk);
        rst = 1'b1;
        det_s = 1'b0;
        emg = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
